regs_file: RTL and testbench
============================

// Module: regs_file
// PURPOSE
//  32 x 32-bit general-purpose register file for the single-cycle datapath; sits directly upstream of the ALU.
//  Two combinational read ports drive ALU A and B operands; one synchronous write port takes the write-back result.
//  A third read-only debug port exposes any register to the board display logic.
// PARAMETERS
//  DATA_W    32   register width in bits
//  ADDR_W    5    register address width; register count = 2**ADDR_W
// PORTS
//  clk        in   1       system clock, rising-edge active
//  rst_n      in   1       asynchronous, active-low reset
//  R_addr_A   in   5       read port A address (feeds ALU A)
//  R_addr_B   in   5       read port B address (feeds ALU B)
//  Wt_addr    in   5       write address
//  Wt_data    in   32      write data (ALU res / memory load data)
//  L_S        in   1       write enable, sampled on rising clk
//  rdata_A    out  32      read port A data
//  rdata_B    out  32      read port B data
//  dbg_addr   in   5       debug read address
//  dbg_data   out  32      debug read data
//  wr_cnt     out  16      count of committed writes (debug), saturating
// BEHAVIOUR
//  - Reset: rst_n low clears registers 1..31 and wr_cnt to 0 immediately, with no clk needed; all reads then return 0.
//  - While rst_n is low, writes are ignored. The first write is possible on the first rising clk after rst_n deasserts.
//  - Register 0 is hardwired zero: it has no storage, writes to it are discarded and do not bump wr_cnt, and every port reading it returns 32'h0.
//  - Write: on rising clk, if rst_n & L_S & (Wt_addr != 0), then reg[Wt_addr] <= Wt_data and wr_cnt increments.
//    wr_cnt saturates at 16'hFFFF and never wraps.
//  - Reads: combinational, zero-cycle latency; rdata_X = reg[R_addr_X].
//    A and B may address the same register; both then return the same value.
//  - Write/read same register in one cycle (no bypass): the read returns the OLD value; the new value appears after the rising edge.
//  - Debug port: same semantics as the read ports. It is never bypassed and has no side effects.
//  - No X on outputs at any time after reset; undriven addresses are not possible (full 5-bit decode).
// CONFIGURATION
//  REGS_BYPASS_EN defined:
//    - rdata_A / rdata_B return Wt_data combinationally when L_S & (R_addr_X == Wt_addr) & (Wt_addr != 0).
//    - This is write-through forwarding; it is suppressed while rst_n is low.
//  REGS_BYPASS_EN undefined: plain read-old-value behaviour as above.
//  dbg_data is unaffected by the macro in both cases.
// STRUCTURE
//  - Shared package regs_pkg: DATA_W, ADDR_W, REG_NUM (=32), ZERO_REG (=5'd0), WR_CNT_W (=16).
//  - Sub-module regs_read_port: one address in, 32-bit data out; contains the zero-register force and the optional bypass.
//  - regs_read_port is instantiated three times: A, B, and debug with bypass tied off.
//  - Storage lives in regs_file as reg [31:0] r [1:31] with one async-reset always block.
// TESTING
//  1. Reset: pulse rst_n low mid-clock after r5=32'h1234 -> rdata of r5 is 0 immediately, wr_cnt=0.
//  2. Write r1=32'hFFFF0000 and r2=32'h00000FFF, then set R_addr_A=1, R_addr_B=2 -> rdata_A=FFFF0000, rdata_B=00000FFF, wr_cnt=2.
//  3. L_S=1, Wt_addr=0, Wt_data=32'hDEADBEEF -> r0 reads 0 on A, B and dbg; wr_cnt unchanged.
//  4. Same-cycle write r3=32'hA5A5A5A5 with R_addr_A=3 (old 0):
//     - without macro: rdata_A=0 before the edge, A5A5A5A5 after;
//     - with REGS_BYPASS_EN: A5A5A5A5 before the edge; dbg_data=0 before the edge in both builds.
//  5. L_S=0 with Wt_addr=4 and Wt_data=32'h1 across 3 clocks -> r4 stays 0; wr_cnt unchanged.
//  6. Force wr_cnt near its limit by writing 65537 times -> wr_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/regs_pkg.sv
// Shared widths, constants and the write-request payload for the register file.
package regs_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned REG_NUM  = 2 ** ADDR_W;
    localparam int unsigned WR_CNT_W = 16;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  en;
        addr_t addr;
        data_t data;
    } wr_req_t;

endpackage

// File: rtl/regs_file_if.sv
// Register-file bus: two ALU read ports, write-back port, debug port and write counter.
interface regs_file_if;
    import regs_pkg::*;

    addr_t                 R_addr_A;
    addr_t                 R_addr_B;
    addr_t                 Wt_addr;
    data_t                 Wt_data;
    logic                  L_S;
    data_t                 rdata_A;
    data_t                 rdata_B;
    addr_t                 dbg_addr;
    data_t                 dbg_data;
    logic [WR_CNT_W-1:0]   wr_cnt;

    modport master (
        output R_addr_A, R_addr_B, Wt_addr, Wt_data, L_S, dbg_addr,
        input  rdata_A, rdata_B, dbg_data, wr_cnt
    );

    modport slave (
        input  R_addr_A, R_addr_B, Wt_addr, Wt_data, L_S, dbg_addr,
        output rdata_A, rdata_B, dbg_data, wr_cnt
    );

endinterface

// File: rtl/regs_read_port.sv
// One combinational read port: zero-register force plus optional write-through forwarding.
module regs_read_port
    import regs_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b0
) (
    input  logic                             rst_n,
    input  addr_t                            rd_addr,
    input  logic [REG_NUM-1:0][DATA_W-1:0]   regs_i,
    input  wr_req_t                          wr_i,
    output data_t                            rd_data_c
);

    logic fwd_hit;

    always_comb begin
        fwd_hit   = 1'b0;
        rd_data_c = '0;
        // Forwarding is only live outside reset and never for the hardwired zero register.
        fwd_hit = BYPASS_EN && rst_n && wr_i.en
                  && (rd_addr == wr_i.addr) && (wr_i.addr != ZERO_REG);
        if (rd_addr == ZERO_REG) begin
            rd_data_c = '0;
        end else if (fwd_hit) begin
            rd_data_c = wr_i.data;
        end else begin
            rd_data_c = regs_i[rd_addr];
        end
    end

endmodule

// File: rtl/regs_file.sv
// 32 x 32 register file: r0 hardwired zero, async-reset storage for r1..r31, saturating write counter.
// Define REGS_BYPASS_EN to forward write data onto the ALU read ports in the same cycle.
module regs_file
    import regs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    regs_file_if.slave  bus
);

`ifdef REGS_BYPASS_EN
    localparam bit ALU_BYPASS = 1'b1;
`else
    localparam bit ALU_BYPASS = 1'b0;
`endif

    data_t                          regs_q [1:REG_NUM-1];
    data_t                          regs_d [1:REG_NUM-1];
    logic [WR_CNT_W-1:0]            wr_cnt_q;
    logic [WR_CNT_W-1:0]            wr_cnt_d;
    logic [REG_NUM-1:0][DATA_W-1:0] regs_flat;
    wr_req_t                        wr_req;
    logic                           write_hit;

    assign wr_req    = '{en: bus.L_S, addr: bus.Wt_addr, data: bus.Wt_data};
    assign write_hit = wr_req.en && (wr_req.addr != ZERO_REG);

    // Next-state: single write port plus saturating commit counter.
    always_comb begin
        regs_d   = regs_q;
        wr_cnt_d = wr_cnt_q;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (write_hit && (wr_req.addr == ADDR_W'(i))) begin
                regs_d[i] = wr_req.data;
            end
        end
        if (write_hit && (wr_cnt_q != {WR_CNT_W{1'b1}})) begin
            wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Flattened view for the read ports; slot 0 has no storage.
    always_comb begin
        regs_flat[0] = '0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            regs_flat[i] = regs_q[i];
        end
    end

    regs_read_port #(.BYPASS_EN(ALU_BYPASS)) u_port_a (
        .rst_n     (rst_n),
        .rd_addr   (bus.R_addr_A),
        .regs_i    (regs_flat),
        .wr_i      (wr_req),
        .rd_data_c (bus.rdata_A)
    );

    regs_read_port #(.BYPASS_EN(ALU_BYPASS)) u_port_b (
        .rst_n     (rst_n),
        .rd_addr   (bus.R_addr_B),
        .regs_i    (regs_flat),
        .wr_i      (wr_req),
        .rd_data_c (bus.rdata_B)
    );

    regs_read_port #(.BYPASS_EN(1'b0)) u_port_dbg (
        .rst_n     (rst_n),
        .rd_addr   (bus.dbg_addr),
        .regs_i    (regs_flat),
        .wr_i      (wr_req),
        .rd_data_c (bus.dbg_data)
    );

    assign bus.wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regs_file.sv
// Self-checking bench for regs_file against an array-based register model.
module tb_regs_file;
    import regs_pkg::*;

`ifdef REGS_BYPASS_EN
    localparam bit BYPASS_BUILD = 1'b1;
`else
    localparam bit BYPASS_BUILD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regs_file_if bus();

    regs_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] model [32];
    int unsigned model_cnt;
    int          checks = 0;
    int          errors = 0;

    // Expected read value from the architectural model.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit alu_port);
        if (a == 5'd0) return 32'h0;
        if (BYPASS_BUILD && alu_port && rst_n && bus.L_S && (a == bus.Wt_addr))
            return bus.Wt_data;
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model_cnt = 0;
    endtask

    task automatic set_in(input logic [4:0] la, input logic [4:0] lb, input logic [4:0] ld,
                          input logic ls, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        bus.R_addr_A = la;
        bus.R_addr_B = lb;
        bus.dbg_addr = ld;
        bus.L_S      = ls;
        bus.Wt_addr  = wa;
        bus.Wt_data  = wd;
        #1;
    endtask

    // Apply one rising edge to the model, then settle.
    task automatic clk_edge();
        @(posedge clk);
        if (rst_n && bus.L_S && (bus.Wt_addr != 5'd0)) begin
            model[bus.Wt_addr] = bus.Wt_data;
            if (model_cnt < 65535) model_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        bus.R_addr_A = 5'd0; bus.R_addr_B = 5'd0; bus.dbg_addr = 5'd0;
        bus.L_S = 1'b0; bus.Wt_addr = 5'd0; bus.Wt_data = 32'h0;
        model_reset();
        #2;
        for (int i = 0; i < 32; i++) begin
            bus.dbg_addr = 5'(i);
            #1;
            checks++;
            if (bus.dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_dbg r%0d: got %h expected %h", i, bus.dbg_data, 32'h0);
            end
        end
        // Writes while in reset are ignored and not forwarded.
        bus.L_S = 1'b1; bus.Wt_addr = 5'd7; bus.Wt_data = 32'hCAFE0007; bus.R_addr_A = 5'd7;
        bus.dbg_addr = 5'd7;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (bus.rdata_A !== 32'h0 || bus.dbg_data !== 32'h0 || bus.wr_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_write_ignored: A=%h dbg=%h cnt=%h expected 0/0/0",
                     bus.rdata_A, bus.dbg_data, bus.wr_cnt);
        end
        @(negedge clk);
        bus.L_S = 1'b0;
        rst_n = 1'b1;
        // Write r5, then assert reset mid-cycle.
        set_in(5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 32'h0000_1234);
        clk_edge();
        bus.L_S = 1'b0;
        #1;
        checks++;
        if (bus.dbg_data !== 32'h0000_1234 || bus.wr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset_r5: dbg=%h cnt=%0d expected %h/1", bus.dbg_data, bus.wr_cnt, 32'h1234);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.rdata_A !== 32'h0 || bus.dbg_data !== 32'h0 || bus.wr_cnt !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: A=%h dbg=%h cnt=%h expected 0/0/0",
                     bus.rdata_A, bus.dbg_data, bus.wr_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_write();
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 5'd1, 32'hFFFF_0000);
        clk_edge();
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h0000_0FFF);
        clk_edge();
        set_in(5'd1, 5'd2, 5'd1, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.rdata_A !== exp_rd(5'd1, 1'b1) || bus.rdata_A !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL basic_A: got %h expected %h", bus.rdata_A, 32'hFFFF_0000);
        end
        checks++;
        if (bus.rdata_B !== exp_rd(5'd2, 1'b1) || bus.rdata_B !== 32'h0000_0FFF) begin
            errors++;
            $display("FAIL basic_B: got %h expected %h", bus.rdata_B, 32'h0000_0FFF);
        end
        checks++;
        if (bus.wr_cnt !== 16'(model_cnt) || bus.wr_cnt !== 16'd2) begin
            errors++;
            $display("FAIL basic_cnt: got %0d expected %0d", bus.wr_cnt, 2);
        end
        set_in(5'd2, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.rdata_A !== 32'h0000_0FFF || bus.rdata_B !== 32'h0000_0FFF) begin
            errors++;
            $display("FAIL same_addr_AB: A=%h B=%h expected %h", bus.rdata_A, bus.rdata_B, 32'h0FFF);
        end
    endtask

    task automatic test_zero_reg();
        logic [15:0] cnt_before;
        cnt_before = bus.wr_cnt;
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        checks++;
        if (bus.rdata_A !== 32'h0 || bus.rdata_B !== 32'h0 || bus.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL zero_pre: A=%h B=%h dbg=%h expected 0", bus.rdata_A, bus.rdata_B, bus.dbg_data);
        end
        clk_edge();
        checks++;
        if (bus.rdata_A !== 32'h0 || bus.rdata_B !== 32'h0 || bus.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL zero_post: A=%h B=%h dbg=%h expected 0", bus.rdata_A, bus.rdata_B, bus.dbg_data);
        end
        checks++;
        if (bus.wr_cnt !== cnt_before || bus.wr_cnt !== 16'(model_cnt)) begin
            errors++;
            $display("FAIL zero_cnt: got %0d expected %0d", bus.wr_cnt, cnt_before);
        end
    endtask

    task automatic test_same_cycle();
        set_in(5'd3, 5'd0, 5'd3, 1'b1, 5'd3, 32'hA5A5_A5A5);
        checks++;
        if (bus.rdata_A !== exp_rd(5'd3, 1'b1) ||
            bus.rdata_A !== (BYPASS_BUILD ? 32'hA5A5_A5A5 : 32'h0)) begin
            errors++;
            $display("FAIL same_cycle_A_pre: got %h expected %h", bus.rdata_A, exp_rd(5'd3, 1'b1));
        end
        checks++;
        if (bus.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_dbg_pre: got %h expected %h", bus.dbg_data, 32'h0);
        end
        clk_edge();
        bus.L_S = 1'b0;
        #1;
        checks++;
        if (bus.rdata_A !== 32'hA5A5_A5A5 || bus.dbg_data !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL same_cycle_post: A=%h dbg=%h expected %h", bus.rdata_A, bus.dbg_data, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_no_write();
        logic [15:0] cnt_before;
        cnt_before = bus.wr_cnt;
        set_in(5'd4, 5'd4, 5'd4, 1'b0, 5'd4, 32'h1);
        repeat (3) clk_edge();
        checks++;
        if (bus.dbg_data !== 32'h0 || bus.rdata_A !== 32'h0 || bus.wr_cnt !== cnt_before) begin
            errors++;
            $display("FAIL no_write: dbg=%h A=%h cnt=%0d expected 0/0/%0d",
                     bus.dbg_data, bus.rdata_A, bus.wr_cnt, cnt_before);
        end
    endtask

    task automatic test_random();
        logic [4:0] la, lb, ld, wa;
        logic       ls;
        for (int n = 0; n < 300; n++) begin
            wa = 5'($urandom_range(0, 31));
            la = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            lb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ld = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ls = 1'($urandom_range(0, 1));
            set_in(la, lb, ld, ls, wa, $urandom);
            checks++;
            if (bus.rdata_A !== exp_rd(la, 1'b1) || bus.rdata_B !== exp_rd(lb, 1'b1) ||
                bus.dbg_data !== exp_rd(ld, 1'b0)) begin
                errors++;
                $display("FAIL rand_read n=%0d: A=%h/%h B=%h/%h dbg=%h/%h (got/expected)", n,
                         bus.rdata_A, exp_rd(la, 1'b1), bus.rdata_B, exp_rd(lb, 1'b1),
                         bus.dbg_data, exp_rd(ld, 1'b0));
            end
            clk_edge();
            checks++;
            if (bus.wr_cnt !== 16'(model_cnt)) begin
                errors++;
                $display("FAIL rand_cnt n=%0d: got %0d expected %0d", n, bus.wr_cnt, model_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(5'd9, 5'd0, 5'd9, 1'b1, 5'd9, 32'h0);
        for (int i = 0; i < 65534; i++) begin
            bus.Wt_data = 32'(i);
            clk_edge();
        end
        checks++;
        if (bus.wr_cnt !== 16'hFFFE || bus.wr_cnt !== 16'(model_cnt)) begin
            errors++;
            $display("FAIL sat_near: got %h expected %h", bus.wr_cnt, 16'hFFFE);
        end
        clk_edge();
        checks++;
        if (bus.wr_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: got %h expected %h", bus.wr_cnt, 16'hFFFF);
        end
        clk_edge();
        clk_edge();
        bus.L_S = 1'b0;
        #1;
        checks++;
        if (bus.wr_cnt !== 16'hFFFF || bus.wr_cnt !== 16'(model_cnt)) begin
            errors++;
            $display("FAIL sat_hold: got %h expected %h", bus.wr_cnt, 16'hFFFF);
        end
        checks++;
        if (bus.dbg_data !== model[9]) begin
            errors++;
            $display("FAIL sat_data: got %h expected %h", bus.dbg_data, model[9]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_same_cycle();
        test_no_write();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
